perf_monitor_window_ctrl: RTL and testbench



---
 rtl/perf_monitor_window_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_perf_monitor_window_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor_window_ctrl.sv
// perf_monitor_window_ctrl
// ------------------------
// Measurement sequencer for the bus performance monitor. One set of window
// statistics is shared among NUM_CH monitored valid/ready channels. Channels
// are picked round-robin from ch_mask_i. Each pick runs a window of
// max(window_len_i,1) cycles. The window collects request and completion
// handshake counts, the sum of the outstanding count over all cycles, and the
// peak outstanding count. occ_sum / out_cnt then gives the mean latency
// (Little's law).
//
// Optional feature (compile-time macro PERF_MON_MAX_OCC_EN):
//   defined   - peak-occupancy register is built; result_max_occ_o reports it.
//   undefined - no peak register; result_max_occ_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   enable_i                run the sampling sequence
//   ch_mask_i               channels eligible for selection
//   window_len_i            window length in cycles (0 behaves as 1)
//   inp_valid_i/ready_i     per-channel request-side handshake
//   oup_valid_i/ready_i     per-channel completion-side handshake
//   result_valid_o/ready_i  result handshake
//   result_ch_o             measured channel index
//   result_in_cnt_o         request handshakes in the window
//   result_out_cnt_o        completion handshakes in the window
//   result_occ_sum_o        sum of the outstanding count over window cycles
//   result_max_occ_o        peak outstanding count (0 when feature is off)
//   busy_o                  FSM is not in IDLE
//   state_o                 FSM state: 0 IDLE, 1 SELECT, 2 MEASURE, 3 REPORT
//
// Result handshake: result_valid_o is high only in REPORT. While it is high,
// every result_* output holds stable. A transfer happens on a clock edge
// where result_valid_o and result_ready_i are both high.
// CNT_WIDTH must be >= OCC_WIDTH.

module perf_monitor_window_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32,
    parameter int OCC_WIDTH = 8,
    parameter int WIN_WIDTH = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [NUM_CH-1:0]    ch_mask_i,
    input  logic [WIN_WIDTH-1:0] window_len_i,
    input  logic [NUM_CH-1:0]    inp_valid_i,
    input  logic [NUM_CH-1:0]    inp_ready_i,
    input  logic [NUM_CH-1:0]    oup_valid_i,
    input  logic [NUM_CH-1:0]    oup_ready_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [CH_W-1:0]      result_ch_o,
    output logic [CNT_WIDTH-1:0] result_in_cnt_o,
    output logic [CNT_WIDTH-1:0] result_out_cnt_o,
    output logic [CNT_WIDTH-1:0] result_occ_sum_o,
    output logic [OCC_WIDTH-1:0] result_max_occ_o,
    output logic                 busy_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SELECT  = 2'd1,
        S_MEASURE = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    localparam int                   SUM_W   = CNT_WIDTH + 1;
    localparam logic [OCC_WIDTH-1:0] OCC_MAX = '1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_CH-1:0]    w_inc;
    logic [NUM_CH-1:0]    w_dec;
    logic [OCC_WIDTH-1:0] r_occ [NUM_CH];
    logic [OCC_WIDTH-1:0] w_occ_sel;
    logic [CH_W-1:0]      r_sel;
    logic [CH_W-1:0]      r_last;
    logic [CH_W-1:0]      w_next_ch;
    logic [WIN_WIDTH-1:0] r_cnt;
    logic [WIN_WIDTH-1:0] w_len;
    logic [CNT_WIDTH-1:0] r_in;
    logic [CNT_WIDTH-1:0] r_out;
    logic [CNT_WIDTH-1:0] r_sum;
    logic                 w_any;

    assign w_inc     = inp_valid_i & inp_ready_i;
    assign w_dec     = oup_valid_i & oup_ready_i;
    assign w_any     = |ch_mask_i;
    assign w_len     = (window_len_i == '0) ? WIN_WIDTH'(1) : window_len_i;
    assign w_occ_sel = r_occ[r_sel];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] a,
                                                     input logic b);
        return (b && (a != '1)) ? a + 1'b1 : a;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [OCC_WIDTH-1:0] b);
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + SUM_W'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // Outstanding counters run in every state. A simultaneous request and
    // completion cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) r_occ[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_inc[c] && !w_dec[c] && (r_occ[c] != OCC_MAX))
                    r_occ[c] <= r_occ[c] + 1'b1;
                else if (w_dec[c] && !w_inc[c] && (r_occ[c] != '0))
                    r_occ[c] <= r_occ[c] - 1'b1;
            end
        end
    end

    // First eligible channel strictly after r_last, wrapping around.
    always_comb begin : b_next_ch
        logic            v_found;
        logic [CH_W-1:0] v_idx;
        w_next_ch = r_last;
        v_found   = 1'b0;
        v_idx     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            v_idx = CH_W'((int'(r_last) + i) % NUM_CH);
            if (!v_found && ch_mask_i[v_idx]) begin
                w_next_ch = v_idx;
                v_found   = 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (enable_i && w_any) w_state_nxt = S_SELECT;
            S_SELECT:  w_state_nxt = w_any ? S_MEASURE : S_IDLE;
            S_MEASURE: if (r_cnt == WIN_WIDTH'(1)) w_state_nxt = S_REPORT;
            S_REPORT:  if (result_ready_i) w_state_nxt = enable_i ? S_SELECT : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        result_valid_o = (r_state == S_REPORT);
        busy_o         = (r_state != S_IDLE);
        state_o        = r_state;
    end

    // Window datapath. The accumulators only move in MEASURE, so they stay
    // stable through REPORT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sel  <= '0;
            r_last <= CH_W'(NUM_CH - 1);
            r_cnt  <= '0;
            r_in   <= '0;
            r_out  <= '0;
            r_sum  <= '0;
        end else begin
            case (r_state)
                S_SELECT: if (w_any) begin
                    r_sel <= w_next_ch;
                    r_cnt <= w_len;
                    r_in  <= '0;
                    r_out <= '0;
                    r_sum <= '0;
                end
                S_MEASURE: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_in  <= sat_inc(r_in, w_inc[r_sel]);
                    r_out <= sat_inc(r_out, w_dec[r_sel]);
                    r_sum <= sat_add(r_sum, w_occ_sel);
                end
                S_REPORT: if (result_ready_i) r_last <= r_sel;
                default: ;
            endcase
        end
    end

`ifdef PERF_MON_MAX_OCC_EN
    logic [OCC_WIDTH-1:0] r_max;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_max <= '0;
        end else if ((r_state == S_SELECT) && w_any) begin
            r_max <= '0;
        end else if ((r_state == S_MEASURE) && (w_occ_sel > r_max)) begin
            r_max <= w_occ_sel;
        end
    end

    assign result_max_occ_o = r_max;
`else
    assign result_max_occ_o = '0;
`endif

    assign result_ch_o      = r_sel;
    assign result_in_cnt_o  = r_in;
    assign result_out_cnt_o = r_out;
    assign result_occ_sum_o = r_sum;

endmodule

// File: tb/tb_perf_monitor_window_ctrl.sv
// Testbench for perf_monitor_window_ctrl.
// Directed windows are issued and their hand-computed results are pushed to
// exp_q. A monitor pops and compares on each result transfer. A second
// instance with OCC_WIDTH=2 covers outstanding-counter saturation.
`timescale 1ns/1ps

module tb_perf_monitor_window_ctrl;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int OCC_W  = 8;
    localparam int WIN_W  = 16;
    localparam int CH_W   = 2;
    localparam int EW     = CH_W + 3 * CNT_W + OCC_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SELECT  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_REPORT  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main DUT signals
    logic              en, res_ready, res_valid, busy;
    logic [NUM_CH-1:0] mask, iv, ir, ov, orr;
    logic [WIN_W-1:0]  len;
    logic [CH_W-1:0]   res_ch;
    logic [CNT_W-1:0]  res_in, res_out, res_sum;
    logic [OCC_W-1:0]  res_max;
    logic [1:0]        state;

    // saturation DUT signals
    logic              s_en, s_valid, s_busy;
    logic [NUM_CH-1:0] s_req;
    logic [CH_W-1:0]   s_ch;
    logic [CNT_W-1:0]  s_in, s_out, s_sum;
    logic [1:0]        s_max, s_state;

    perf_monitor_window_ctrl #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_W), .OCC_WIDTH(OCC_W), .WIN_WIDTH(WIN_W)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .ch_mask_i(mask),
        .window_len_i(len), .inp_valid_i(iv), .inp_ready_i(ir),
        .oup_valid_i(ov), .oup_ready_i(orr), .result_valid_o(res_valid),
        .result_ready_i(res_ready), .result_ch_o(res_ch),
        .result_in_cnt_o(res_in), .result_out_cnt_o(res_out),
        .result_occ_sum_o(res_sum), .result_max_occ_o(res_max),
        .busy_o(busy), .state_o(state)
    );

    perf_monitor_window_ctrl #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_W), .OCC_WIDTH(2), .WIN_WIDTH(WIN_W)
    ) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(s_en), .ch_mask_i(4'b0001),
        .window_len_i(16'd2), .inp_valid_i(s_req), .inp_ready_i(s_req),
        .oup_valid_i(4'b0000), .oup_ready_i(4'b0000), .result_valid_o(s_valid),
        .result_ready_i(1'b1), .result_ch_o(s_ch),
        .result_in_cnt_o(s_in), .result_out_cnt_o(s_out),
        .result_occ_sum_o(s_sum), .result_max_occ_o(s_max),
        .busy_o(s_busy), .state_o(s_state)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;

    function automatic int mx(input int v);
`ifdef PERF_MON_MAX_OCC_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic logic [EW-1:0] pack(input int ch, input int in_c, input int out_c,
                                           input int sum, input int mxv);
        return {CH_W'(ch), CNT_W'(in_c), CNT_W'(out_c), CNT_W'(sum), OCC_W'(mxv)};
    endfunction

    // Monitor: a transfer happens at the next posedge when valid&ready are
    // high at the negedge.
    always @(negedge clk) begin
        logic [EW-1:0] got, exp;
        if (rst_n && res_valid && res_ready) begin
            got = {res_ch, res_in, res_out, res_sum, res_max};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL result_unexpected got=%h", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL result ch/in/out/sum/max got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d",
                             res_ch, res_in, res_out, res_sum, res_max,
                             exp[EW-1 -: CH_W], exp[EW-CH_W-1 -: CNT_W],
                             exp[EW-CH_W-CNT_W-1 -: CNT_W], exp[OCC_W +: CNT_W],
                             exp[OCC_W-1:0]);
                end
            end
            n_pop++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // One clock cycle of handshakes: req / cmp are per-channel masks.
    task automatic step(input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] cmp);
        iv  = req;
        ir  = req;
        ov  = cmp;
        orr = cmp;
        @(posedge clk);
        #1;
        iv  = '0;
        ir  = '0;
        ov  = '0;
        orr = '0;
    endtask

    task automatic wait_pops(input int target, input int budget);
        for (int k = 0; k < budget && n_pop < target; k++) step('0, '0);
        if (n_pop < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_timeout got=%0d exp=%0d", n_pop, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        rst_n = 1'b0; en = 0; res_ready = 0; mask = '0; len = '0;
        iv = '0; ir = '0; ov = '0; orr = '0; s_en = 0; s_req = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset values
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state, ST_IDLE);
        chk("rst_data", {res_ch, res_in, res_out, res_sum, res_max}, 0);

        // saturation at OCC_WIDTH=2: five requests leave occ at 3
        s_req = 4'b0001;
        repeat (5) step('0, '0);
        s_req = '0;
        s_en = 1;
        step('0, '0);
        s_en = 0;
        for (int k = 0; k < 10 && !s_valid; k++) step('0, '0);
        chk("sat_valid", s_valid, 1);
        chk("sat_result", {s_ch, s_in, s_out, s_sum, s_max},
            {2'd0, 32'd0, 32'd0, 32'd6, 2'(mx(3))});

        // single window on ch0, L=10, result_ready held low
        mask = 4'b0001; len = 16'd10; en = 1; res_ready = 0;
        exp_q.push_back(pack(0, 3, 2, 13, mx(2)));
        step('0, '0);
        chk("t1_select", state, ST_SELECT);
        step('0, '0);
        begin
            logic [9:0] pr, pc;
            pr = 10'b0000010011;   // requests in MEASURE cycles 0,1,4
            pc = 10'b0001001000;   // completions in MEASURE cycles 3,6
            for (int m = 0; m < 10; m++) begin
                if (m == 9) chk("t1_valid_early", res_valid, 0);
                step({3'b000, pr[m]}, {3'b000, pc[m]});
            end
        end
        chk("t1_valid_on_time", res_valid, 1);
        en = 0;
        res_ready = 1;
        base = n_pop;
        wait_pops(base + 1, 5);
        chk("t1_idle_after", {busy, state}, {1'b0, ST_IDLE});
        step('0, 4'b0001);         // drain ch0 back to occ 0

        // round robin over mask 1010, then mask 0100 mid-window
        mask = 4'b1010; len = 16'd3; en = 1; res_ready = 1;
        exp_q.push_back(pack(1, 0, 0, 0, 0));
        exp_q.push_back(pack(3, 0, 0, 0, 0));
        exp_q.push_back(pack(1, 0, 0, 0, 0));
        exp_q.push_back(pack(3, 0, 0, 0, 0));
        exp_q.push_back(pack(1, 0, 0, 0, 0));
        exp_q.push_back(pack(2, 0, 0, 0, 0));
        base = n_pop;
        wait_pops(base + 4, 60);
        chk("t2_select_after_accept", state, ST_SELECT);
        step('0, '0);
        mask = 4'b0100;
        wait_pops(base + 5, 20);
        step('0, '0);
        en = 0;
        wait_pops(base + 6, 20);
        chk("t2_idle", busy, 0);

        // occupancy integral on ch2, L=32
        mask = 4'b0100; len = 16'd32; en = 1;
        exp_q.push_back(pack(2, 4, 4, 40, mx(4)));
        step('0, '0);
        en = 0;
        step('0, '0);
        for (int m = 0; m < 32; m++) begin
            logic [NUM_CH-1:0] rq, cp;
            rq = (m < 4) ? 4'b0100 : 4'b0000;
            cp = (m >= 10 && m < 14) ? 4'b0100 : 4'b0000;
            if (m == 5) begin
                rq = 4'b0010;      // simultaneous pair on an unselected channel
                cp = 4'b0010;
            end
            step(rq, cp);
        end
        base = n_pop;
        wait_pops(base + 1, 5);
        chk("t3_idle", busy, 0);

        // L=0 acts as L=1; simultaneous request+completion leaves occ unchanged
        step(4'b0001, '0);
        step(4'b0001, 4'b0001);
        mask = 4'b0001; len = 16'd0; en = 1;
        exp_q.push_back(pack(0, 1, 0, 1, mx(1)));
        step('0, '0);
        en = 0;
        step('0, '0);
        step(4'b0001, '0);
        base = n_pop;
        wait_pops(base + 1, 5);

        // completion at occ=0 on ch3 is ignored
        step('0, 4'b1000);
        mask = 4'b1000; len = 16'd2; en = 1;
        exp_q.push_back(pack(3, 0, 0, 0, 0));
        step('0, '0);
        en = 0;
        wait_pops(base + 2, 10);

        // backpressure: ready low 20 cycles, occ0 = 2 going in
        mask = 4'b0001; len = 16'd2; en = 1; res_ready = 0;
        exp_q.push_back(pack(0, 0, 0, 4, mx(2)));
        for (int k = 0; k < 10 && !res_valid; k++) step('0, '0);
        chk("t5_valid", res_valid, 1);
        for (int k = 0; k < 20; k++) begin
            step((k == 0) ? 4'b0001 : 4'b0000, '0);   // request in REPORT is not counted
            chk("t5_hold", {res_valid, state, res_ch, res_in, res_out, res_sum, res_max},
                {1'b1, ST_REPORT, 2'd0, 32'd0, 32'd0, 32'd4, 8'(mx(2))});
        end
        res_ready = 1;
        base = n_pop;
        step('0, '0);
        chk("t5_select_next", state, ST_SELECT);
        en = 0;                    // dropped mid-window: result still reported
        exp_q.push_back(pack(0, 0, 0, 6, mx(3)));
        wait_pops(base + 2, 10);
        chk("t5_idle", {busy, state}, {1'b0, ST_IDLE});

        // asynchronous reset during MEASURE
        mask = 4'b1111; len = 16'd20; en = 1;
        step('0, '0);
        step('0, '0);
        repeat (3) step(4'b1000, '0);
        chk("t6_measuring", {state, res_ch}, {ST_MEASURE, 2'd1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", {res_valid, busy, state, res_ch, res_in, res_out, res_sum, res_max}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mask = 4'b1001; len = 16'd1;
        exp_q.push_back(pack(0, 0, 0, 0, 0));
        exp_q.push_back(pack(3, 0, 0, 0, 0));
        base = n_pop;
        wait_pops(base + 1, 10);
        en = 0;
        wait_pops(base + 2, 10);
        chk("t6_idle", busy, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
